// File: rtl/cmos_i2c_responder.sv
`default_nettype none
// ==========================================================================
// cmos_i2c_responder : I2C target with a 256x8 RAM, word pointer and host preload port
// Rev 1.0 - initial release
// ==========================================================================
module cmos_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       i2c_clock,
  input  logic       i2c_din,
  output logic       i2c_dout,
  input  logic       cfg_we,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_din,
  output logic [7:0] cfg_dout,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, WA, ACK_WA, WDATA, ACK_WR, RDATA, MACK
  } state_t;

  state_t     state;
  logic [7:0] ram [256];
  logic [7:0] wa;
  logic [6:0] shreg;
  logic [3:0] bit_cnt;
  logic       rw;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det, ram_we;
  logic [7:0] rx_byte;

  // Synchronizers idle high so a reset looks like a quiet bus.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= i2c_clock;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= i2c_din;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte   = {shreg, sda_s2};
  assign ram_we    = (state == WDATA) && scl_rise && (bit_cnt == 4'd7);
  assign busy      = (state != IDLE);

  // bit_cnt counts bits within a byte; in ACK states 8/9 mark the two halves
  // of the acknowledge slot, and 9 in MACK means "master acked, load next byte".
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wa       <= 8'd0;
      shreg    <= 7'd0;
      bit_cnt  <= 4'd0;
      rw       <= 1'b0;
      i2c_dout <= 1'b1;
    end else if (start_det) begin
      state    <= DEV;
      bit_cnt  <= 4'd0;
      i2c_dout <= 1'b1;
    end else if (stop_det) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      i2c_dout <= 1'b1;
    end else begin
      case (state)
        DEV, WA, WDATA: begin
          if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == WA) begin
                wa    <= rx_byte;
                state <= ACK_WA;
              end else if (state == WDATA) begin
                state <= ACK_WR;
              end else if (rx_byte[7:1] == DEV_ADDR) begin
                rw    <= rx_byte[0];
                state <= ACK_DEV;
              end else begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
              end
            end
          end
        end
        ACK_DEV, ACK_WA, ACK_WR: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              i2c_dout <= 1'b0;
              bit_cnt  <= 4'd9;
            end else begin
              bit_cnt  <= 4'd0;
              i2c_dout <= 1'b1;
              if (state == ACK_WR) begin
                wa    <= wa + 8'd1;
                state <= WDATA;
              end else if (state == ACK_WA) begin
                state <= WDATA;
              end else if (rw) begin
                state    <= RDATA;
                shreg    <= ram[wa][6:0];
                i2c_dout <= ram[wa][7];
              end else begin
                state <= WA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            if (bit_cnt == 4'd8) begin
              i2c_dout <= 1'b1;
              bit_cnt  <= 4'd0;
              state    <= MACK;
            end else begin
              i2c_dout <= shreg[6];
              shreg    <= {shreg[5:0], 1'b0};
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              state <= IDLE;
            end else begin
              wa      <= wa + 8'd1;
              bit_cnt <= 4'd9;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            state    <= RDATA;
            bit_cnt  <= 4'd0;
            shreg    <= ram[wa][6:0];
            i2c_dout <= ram[wa][7];
          end
        end
        default: ;
      endcase
    end
  end

  // Bus write is issued last so it takes precedence on an address clash.
  always_ff @(posedge clkcpu) begin
    if (cfg_we) ram[cfg_addr] <= cfg_din;
    if (ram_we) ram[wa] <= rx_byte;
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) cfg_dout <= 8'd0;
    else        cfg_dout <= ram[cfg_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_i2c_responder.sv
`default_nettype none
// ==========================================================================
// tb_cmos_i2c_responder : randomized bench against a byte-level RAM/pointer model
// Rev 1.0 - initial release
// ==========================================================================
module tb_cmos_i2c_responder;
  localparam int Q = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_addr = 8'd0;
  logic [7:0] cfg_din = 8'd0;
  logic       dout;
  logic       busy;
  logic [7:0] cfg_dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] ram_m [256];
  logic [7:0] wa_m = 8'd0;

  cmos_i2c_responder #(.DEV_ADDR(7'h50)) dut (
    .clkcpu(clk), .rst_n(rst_n), .i2c_clock(scl), .i2c_din(sda_m),
    .i2c_dout(dout), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q); scl = 1'b1; tick(H); scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(H / 2); b = dout; tick(H / 2); scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(mack);
  endtask

  // Full write transaction; model: pointer loads, each byte stored then pointer advances.
  task automatic wr_txn(input logic [7:0] a, input logic [7:0] d [4], input int n, output int nacks);
    logic ack;
    nacks = 0;
    bus_start();
    write_byte(8'hA0, ack); if (ack !== 1'b0) nacks++;
    write_byte(a, ack);     if (ack !== 1'b0) nacks++;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack); if (ack !== 1'b0) nacks++;
    end
    bus_stop();
    wa_m = a;
    for (int i = 0; i < n; i++) begin
      ram_m[wa_m] = d[i];
      wa_m = wa_m + 8'd1;
    end
  endtask

  // Read n bytes (ACK all but last); optionally set the pointer first with a repeated start.
  task automatic rd_txn(input logic set_addr, input logic [7:0] a, input int n,
                        output logic [7:0] got [4], output logic [7:0] exp [4], output int nacks);
    logic ack;
    nacks = 0;
    for (int i = 0; i < 4; i++) begin got[i] = 8'd0; exp[i] = 8'd0; end
    bus_start();
    if (set_addr) begin
      write_byte(8'hA0, ack); if (ack !== 1'b0) nacks++;
      write_byte(a, ack);     if (ack !== 1'b0) nacks++;
      bus_start();
      wa_m = a;
    end
    write_byte(8'hA1, ack); if (ack !== 1'b0) nacks++;
    for (int i = 0; i < n; i++) begin
      exp[i] = ram_m[wa_m];
      read_byte(i == n - 1, got[i]);
      if (i < n - 1) wa_m = wa_m + 8'd1;
    end
    bus_stop();
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL rst_dout got %b want 1", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (cfg_dout !== 8'h00) begin errors++; $display("FAIL rst_cfg_dout got %h want 00", cfg_dout); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_preload();
    logic [7:0] x;
    for (int i = 0; i < 256; i++) begin
      cfg_we = 1'b1; cfg_addr = 8'(i); cfg_din = 8'($urandom);
      ram_m[i] = cfg_din;
      tick(1);
    end
    cfg_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      x = 8'($urandom);
      cfg_addr = x; tick(1);
      checks++; if (cfg_dout !== ram_m[x]) begin errors++; $display("FAIL preload_rb[%h] got %h want %h", x, cfg_dout, ram_m[x]); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int nk;
    d[0] = 8'h5A; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    wr_txn(8'h40, d, 1, nk);
    checks++; if (nk !== 0) begin errors++; $display("FAIL wr_acks got %0d nacks want 0", nk); end
    rd_txn(1'b1, 8'h40, 1, got, exp, nk);
    checks++; if (nk !== 0) begin errors++; $display("FAIL rd_acks got %0d nacks want 0", nk); end
    checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL rd_5a got %h want %h", got[0], exp[0]); end
    checks++; if (dout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL after_nack got dout=%b busy=%b want 1 0", dout, busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int nk;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h00; d[3] = 8'h00;
    wr_txn(8'hFF, d, 2, nk);
    checks++; if (nk !== 0) begin errors++; $display("FAIL wrap_acks got %0d want 0", nk); end
    cfg_addr = 8'hFF; tick(1);
    checks++; if (cfg_dout !== ram_m[8'hFF]) begin errors++; $display("FAIL wrap_ff got %h want %h", cfg_dout, ram_m[8'hFF]); end
    cfg_addr = 8'h00; tick(1);
    checks++; if (cfg_dout !== ram_m[8'h00]) begin errors++; $display("FAIL wrap_00 got %h want %h", cfg_dout, ram_m[8'h00]); end
    rd_txn(1'b0, 8'h00, 1, got, exp, nk);
    checks++; if (got[0] !== exp[0] || nk !== 0) begin errors++; $display("FAIL wrap_ptr got %h/%0d want %h/0", got[0], nk, exp[0]); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    bus_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrong_ack got %b want 1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrong_busy got %b want 0", busy); end
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrong_ignore got %b want 1", ack); end
    write_byte(8'h99, ack);
    bus_stop();
    cfg_addr = 8'h40; tick(1);
    checks++; if (cfg_dout !== ram_m[8'h40]) begin errors++; $display("FAIL wrong_ram got %h want %h", cfg_dout, ram_m[8'h40]); end
  endtask

  task automatic test_partial_stop();
    logic ack;
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int nk;
    nk = 0;
    bus_start();
    write_byte(8'hA0, ack); if (ack !== 1'b0) nk++;
    write_byte(8'h30, ack); if (ack !== 1'b0) nk++;
    write_byte(8'hE7, ack); if (ack !== 1'b0) nk++;
    ram_m[8'h30] = 8'hE7; wa_m = 8'h31;
    for (int i = 0; i < 4; i++) write_bit(~ram_m[8'h31][7 - i]);
    bus_stop();
    checks++; if (nk !== 0) begin errors++; $display("FAIL part_acks got %0d want 0", nk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL part_busy got %b want 0", busy); end
    cfg_addr = 8'h31; tick(1);
    checks++; if (cfg_dout !== ram_m[8'h31]) begin errors++; $display("FAIL part_nowrite got %h want %h", cfg_dout, ram_m[8'h31]); end
    rd_txn(1'b0, 8'h00, 1, got, exp, nk);
    checks++; if (got[0] !== exp[0]) begin errors++; $display("FAIL part_ptr got %h want %h", got[0], exp[0]); end
  endtask

  task automatic test_seq_read();
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int nk;
    cfg_we = 1'b1; cfg_addr = 8'h10; cfg_din = 8'hC3; tick(1);
    cfg_we = 1'b0; ram_m[8'h10] = 8'hC3;
    cfg_addr = 8'h0F; tick(1);
    cfg_addr = 8'h10; tick(1);
    checks++; if (cfg_dout !== 8'hC3) begin errors++; $display("FAIL cfg_latency got %h want c3", cfg_dout); end
    rd_txn(1'b1, 8'h0F, 3, got, exp, nk);
    checks++; if (nk !== 0) begin errors++; $display("FAIL seq_acks got %0d want 0", nk); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL seq_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int nk;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    bus_start();
    write_byte(8'hA1, ack);
    tick(1);
    checks++; if (dout !== ram_m[8'h40][7]) begin errors++; $display("FAIL mid_bit7 got %b want %b", dout, ram_m[8'h40][7]); end
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL async_rst got dout=%b busy=%b want 1 0", dout, busy); end
    tick(2);
    rst_n = 1'b1;
    wa_m = 8'h00;
    tick(2);
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL need_start got %b want 1", ack); end
    bus_stop();
    cfg_addr = 8'h40; tick(1);
    checks++; if (cfg_dout !== ram_m[8'h40]) begin errors++; $display("FAIL ram_persist got %h want %h", cfg_dout, ram_m[8'h40]); end
    rd_txn(1'b0, 8'h00, 1, got, exp, nk);
    checks++; if (got[0] !== exp[0] || nk !== 0) begin errors++; $display("FAIL rst_ptr got %h/%0d want %h/0", got[0], nk, exp[0]); end
  endtask

  task automatic test_concurrent_cfg();
    logic [7:0] d [4];
    logic [7:0] a, b, v, last;
    logic done;
    int nk;
    a = 8'($urandom_range(8'h80, 8'hF0));
    b = a - 8'h40;
    v = 8'($urandom);
    last = v;
    done = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    fork
      begin
        wr_txn(a, d, 3, nk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          cfg_we = 1'b1; cfg_addr = b; cfg_din = v;
          tick(1);
          last = v;
          v = v + 8'd1;
        end
        cfg_we = 1'b0;
      end
    join
    ram_m[b] = last;
    checks++; if (nk !== 0) begin errors++; $display("FAIL conc_acks got %0d want 0", nk); end
    for (int i = 0; i < 3; i++) begin
      cfg_addr = a + 8'(i); tick(1);
      checks++; if (cfg_dout !== ram_m[cfg_addr]) begin errors++; $display("FAIL conc_i2c[%h] got %h want %h", cfg_addr, cfg_dout, ram_m[cfg_addr]); end
    end
    cfg_addr = b; tick(1);
    checks++; if (cfg_dout !== ram_m[b]) begin errors++; $display("FAIL conc_cfg[%h] got %h want %h", b, cfg_dout, ram_m[b]); end
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic [7:0] exp [4];
    int nk, n;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      wr_txn(8'($urandom), d, n, nk);
      checks++; if (nk !== 0) begin errors++; $display("FAIL rnd_wr%0d got %0d nacks want 0", it, nk); end
      n = $urandom_range(1, 3);
      rd_txn(1'($urandom), 8'($urandom), n, got, exp, nk);
      checks++; if (nk !== 0) begin errors++; $display("FAIL rnd_rdack%0d got %0d want 0", it, nk); end
      for (int i = 0; i < n; i++) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rnd_rd%0d_%0d got %h want %h", it, i, got[i], exp[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_wrap();
    test_wrong_addr();
    test_partial_stop();
    test_seq_read();
    test_reset_mid();
    test_concurrent_cfg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
